mem_port_arbiter: RTL and testbench

- Owns the single byte-wide RAM/IO port.
- Shares that port between the instruction-fetch requester and the load/store buffer.
- Sequences each multi-byte request as a series of byte cycles, stalls on a full UART buffer, and flushes speculative reads on clear.
- Sits between the instruction queue/LSB and the top-level memory pins, and replaces ad-hoc priority logic.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_rr_picker.sv | 28 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and defaults for the byte-wide memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RD, RD_TAIL, WR} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_W3 = 2'd3} size_t;
  localparam logic [31:0] IO_BASE_DEF = 32'h30000;
  localparam int STARVE_MAX_DEF = 4;
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    return size == SZ_B ? 2'd0 : size == SZ_H ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/mem_rr_picker.sv
// mem_rr_picker: IDLE-time grant between fetch and load/store with an anti-starvation streak
module mem_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] streak;
  logic sat;
  always_comb begin
    sat = streak == SW'(STARVE_MAX);
    grant_ls = en & ls_valid & ~(if_valid & sat);
    grant_if = en & if_valid & ~grant_ls;
  end
  always_ff @(posedge clk) begin
    if (rst) streak <= '0;
    else if (grant_if) streak <= '0;
    else if (grant_ls & ~sat) streak <= streak + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide RAM/IO port between fetch and the load/store buffer
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEF),
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              io_buffer_full,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [1:0]        ls_req_size,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [31:0]       ls_req_wdata,
  output logic              ls_req_ready,
  output logic              ls_resp_valid,
  output logic [31:0]       ls_resp_data,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din
);
  state_t state;
  logic [1:0] k, last;
  logic [ADDR_W-1:0] addr, cur_a, port_a, last_a;
  logic [31:0] wdata, data;
  logic src_if, full_d, stall, resp_if, resp_ls, resp_rd, idle_en, grant_if, grant_ls;
  mem_rr_picker #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk(clk), .rst(rst), .en(idle_en), .if_valid(if_req_valid), .ls_valid(ls_req_valid),
    .grant_if(grant_if), .grant_ls(grant_ls)
  );
  // While frozen the port keeps the last active address so mem_din still
  // matches the byte the counter expects when rdy returns.
  always_comb begin
    idle_en = rdy & ~clear & (state == IDLE);
    cur_a = addr + ADDR_W'(k);
    stall = (state == WR) & ((cur_a == IO_BASE) | (cur_a == IO_BASE + ADDR_W'(4))) & (io_buffer_full | full_d);
    port_a = ((state == RD) | ((state == WR) & ~stall)) ? cur_a : '0;
    mem_a = rdy ? port_a : last_a;
    mem_wr = rdy & (state == WR) & ~stall;
    mem_dout = (state == WR) ? 8'(wdata >> {k, 3'b000}) : 8'h00;
    if_req_ready = grant_if;
    ls_req_ready = grant_ls;
    if_resp_valid = rdy & resp_if & ~clear;
    ls_resp_valid = rdy & resp_ls & ~(clear & resp_rd);
    if_resp_data = data;
    ls_resp_data = data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      last <= '0;
      addr <= '0;
      wdata <= '0;
      data <= '0;
      src_if <= 1'b0;
      full_d <= 1'b0;
      last_a <= '0;
      resp_if <= 1'b0;
      resp_ls <= 1'b0;
      resp_rd <= 1'b0;
    end else if (rdy) begin
      full_d <= io_buffer_full;
      last_a <= port_a;
      resp_if <= 1'b0;
      resp_ls <= 1'b0;
      resp_rd <= 1'b0;
      case (state)
        IDLE: if (grant_if | grant_ls) begin
          addr <= grant_if ? if_req_addr : ls_req_addr;
          last <= grant_if ? 2'd3 : last_idx(ls_req_size);
          wdata <= ls_req_wdata;
          src_if <= grant_if;
          data <= '0;
          k <= '0;
          state <= (grant_ls & ls_req_we) ? WR : RD;
        end
        RD: if (clear) begin
          state <= IDLE;
          k <= '0;
        end else begin
          if (k != 2'd0) data[{k - 2'd1, 3'b000} +: 8] <= mem_din;
          k <= k + 2'd1;
          if (k == last) state <= RD_TAIL;
        end
        RD_TAIL: begin
          state <= IDLE;
          k <= '0;
          if (!clear) begin
            data[{last, 3'b000} +: 8] <= mem_din;
            resp_if <= src_if;
            resp_ls <= ~src_if;
            resp_rd <= 1'b1;
          end
        end
        WR: if (!stall) begin
          k <= k + 2'd1;
          if (k == last) begin
            state <= IDLE;
            k <= '0;
            resp_ls <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and directed checks of the memory port arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst, rdy, clear, full;
  logic ifv, ifr, ifrsp, lsv, we, lsr, lsrsp, mem_wr;
  logic [1:0] sz;
  logic [31:0] ifa, ifd, lsa, wd, lsd, mem_a;
  logic [7:0] mem_dout, mem_din;
  logic [7:0] ram [0:65535];
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic clr, ifv, lsv;
    logic [1:0] sz;
    logic [31:0] lsa;
    logic [3:0] ex;
    logic [31:0] ea, ed;
  } vec_t;
  vec_t v [18];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(full),
    .if_req_valid(ifv), .if_req_addr(ifa), .if_req_ready(ifr), .if_resp_valid(ifrsp), .if_resp_data(ifd),
    .ls_req_valid(lsv), .ls_req_we(we), .ls_req_size(sz), .ls_req_addr(lsa), .ls_req_wdata(wd),
    .ls_req_ready(lsr), .ls_resp_valid(lsrsp), .ls_resp_data(lsd),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
  end

  function automatic vec_t mkv(logic c, logic i, logic l, logic [1:0] s, logic [31:0] a,
                               logic [3:0] ex, logic [31:0] ea, logic [31:0] ed);
    return '{c, i, l, s, a, ex, ea, ed};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rdy = 1'b1; clear = 1'b0; full = 1'b0; ifv = 1'b0; lsv = 1'b0; we = 1'b0;
    sz = 2'd0; ifa = 32'h100; lsa = 32'h0; wd = 32'h0;
  endtask

  task automatic grant_ls(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    lsv = 1'b1; we = w; sz = s; lsa = a; wd = d;
    #3;
    chk("ls_accept", 32'(lsr), 32'd1);
    tick();
    lsv = 1'b0;
  endtask

  initial begin
    bit exp_if [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int ngr, nls, cnt;
    logic [31:0] swd;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
    ram[16'h1FFE] = 8'hFF; ram[16'h1FFF] = 8'h80;
    v[0]  = mkv(1'b0, 1'b1, 1'b0, 2'd0, 32'h0,    4'b1000, 32'h0,    32'h0);
    v[1]  = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h100,  32'h0);
    v[2]  = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h101,  32'h0);
    v[3]  = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h102,  32'h0);
    v[4]  = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h103,  32'h0);
    v[5]  = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h0,    32'h0);
    v[6]  = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0010, 32'h0,    32'h513);
    v[7]  = mkv(1'b0, 1'b1, 1'b1, 2'd1, 32'h1FFE, 4'b0100, 32'h0,    32'h0);
    v[8]  = mkv(1'b0, 1'b1, 1'b0, 2'd1, 32'h1FFE, 4'b0000, 32'h1FFE, 32'h0);
    v[9]  = mkv(1'b0, 1'b1, 1'b0, 2'd1, 32'h1FFE, 4'b0000, 32'h1FFF, 32'h0);
    v[10] = mkv(1'b0, 1'b1, 1'b0, 2'd1, 32'h1FFE, 4'b0000, 32'h0,    32'h0);
    v[11] = mkv(1'b0, 1'b1, 1'b0, 2'd1, 32'h1FFE, 4'b1001, 32'h0,    32'h80FF);
    v[12] = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h100,  32'h0);
    v[13] = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h101,  32'h0);
    v[14] = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h102,  32'h0);
    v[15] = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h103,  32'h0);
    v[16] = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0000, 32'h0,    32'h0);
    v[17] = mkv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    4'b0010, 32'h0,    32'h513);

    idle_in();
    rst = 1'b1;
    tick(); tick();
    #3;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_dout", 32'(mem_dout), 32'd0);
    chk("rst_ready", 32'({ifr, lsr}), 32'd0);
    chk("rst_resp", 32'({ifrsp, lsrsp}), 32'd0);
    chk("rst_data", ifd | lsd, 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      clear = v[i].clr; ifv = v[i].ifv; lsv = v[i].lsv; sz = v[i].sz; lsa = v[i].lsa;
      #3;
      chk($sformatf("vec%0d_if_ready", i), 32'(ifr), 32'(v[i].ex[3]));
      chk($sformatf("vec%0d_ls_ready", i), 32'(lsr), 32'(v[i].ex[2]));
      chk($sformatf("vec%0d_if_resp", i), 32'(ifrsp), 32'(v[i].ex[1]));
      chk($sformatf("vec%0d_ls_resp", i), 32'(lsrsp), 32'(v[i].ex[0]));
      chk($sformatf("vec%0d_mem_a", i), mem_a, v[i].ea);
      chk($sformatf("vec%0d_mem_wr", i), 32'(mem_wr), 32'd0);
      if (v[i].ex[1]) chk($sformatf("vec%0d_if_data", i), ifd, v[i].ed);
      if (v[i].ex[0]) chk($sformatf("vec%0d_ls_data", i), lsd, v[i].ed);
      tick();
    end
    idle_in();

    // five LB with fetch always pending: starvation limit forces one fetch
    ifv = 1'b1; lsv = 1'b1; sz = 2'd0; lsa = 32'h1FFE;
    ngr = 0; nls = 0;
    for (int c = 0; c < 100 && ngr < 6; c++) begin
      #3;
      if (lsrsp) chk("lb_data", lsd, 32'hFF);
      if (ifr | lsr) begin
        chk($sformatf("arb_order%0d", ngr), 32'(ifr), 32'(exp_if[ngr]));
        ngr++;
        if (lsr) nls++;
      end
      tick();
      lsv = nls < 5;
    end
    chk("arb_grants", ngr, 6);
    idle_in();
    for (int c = 0; c < 6; c++) tick();

    // SB to the UART with the buffer full for three cycles
    full = 1'b1;
    grant_ls(1'b1, 2'd0, 32'h30000, 32'h41);
    for (int c = 0; c < 2; c++) begin
      #3;
      chk("io_stall_wr", 32'(mem_wr), 32'd0);
      chk("io_stall_a", mem_a, 32'h0);
      tick();
    end
    full = 1'b0;
    #3;
    chk("io_stall_delayed", 32'(mem_wr), 32'd0);
    tick();
    #3;
    chk("io_wr_fire", 32'(mem_wr), 32'd1);
    chk("io_wr_a", mem_a, 32'h30000);
    chk("io_wr_dout", 32'(mem_dout), 32'h41);
    chk("io_resp_early", 32'(lsrsp), 32'd0);
    tick();
    #3;
    chk("io_resp", 32'(lsrsp), 32'd1);
    tick();

    // LW aborted by clear at byte 2
    grant_ls(1'b0, 2'd2, 32'h100, 32'h0);
    tick(); tick();
    clear = 1'b1;
    #3;
    chk("clr_rd_a", mem_a, 32'h102);
    tick();
    clear = 1'b0;
    #3;
    chk("clr_idle_a", mem_a, 32'h0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #3;
      if (lsrsp) cnt++;
      tick();
    end
    chk("clr_no_resp", cnt, 0);

    // clear coinciding with the load response suppresses it
    grant_ls(1'b0, 2'd2, 32'h100, 32'h0);
    for (int c = 0; c < 5; c++) tick();
    clear = 1'b1;
    #3;
    chk("clr_resp_suppr", 32'(lsrsp), 32'd0);
    tick();
    clear = 1'b0;
    #3;
    chk("clr_resp_gone", 32'(lsrsp), 32'd0);
    tick();

    // SW continues through clear and still responds
    swd = 32'hDDCCBBAA;
    grant_ls(1'b1, 2'd2, 32'h200, swd);
    for (int b = 0; b < 4; b++) begin
      clear = b == 1;
      #3;
      chk($sformatf("sw_wr%0d", b), 32'(mem_wr), 32'd1);
      chk($sformatf("sw_a%0d", b), mem_a, 32'h200 + b);
      chk($sformatf("sw_dout%0d", b), 32'(mem_dout), 32'(swd[8*b +: 8]));
      tick();
    end
    clear = 1'b1; lsv = 1'b1; we = 1'b0; sz = 2'd0; lsa = 32'h1FFE;
    #3;
    chk("sw_resp_clear", 32'(lsrsp), 32'd1);
    chk("clr_no_grant", 32'(lsr), 32'd0);
    tick();
    idle_in();
    tick();

    // rdy low for two cycles in the middle of an LW
    grant_ls(1'b0, 2'd2, 32'h100, 32'h0);
    tick(); tick();
    rdy = 1'b0; ifv = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk("frz_wr", 32'(mem_wr), 32'd0);
      chk("frz_ready", 32'({ifr, lsr}), 32'd0);
      tick();
    end
    rdy = 1'b1; ifv = 1'b0;
    #3;
    chk("frz_resume_a", mem_a, 32'h102);
    tick(); tick();
    #3;
    chk("frz_tail_noresp", 32'(lsrsp), 32'd0);
    chk("frz_tail_a", mem_a, 32'h0);
    tick();
    #3;
    chk("frz_resp", 32'(lsrsp), 32'd1);
    chk("frz_data", lsd, 32'h513);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
